uart_mem_bridge: RTL

- Host-side command engine on the user side of the UART: consumes received bytes (rx_data/rx_ready) and drives bytes back to it (tx_data/tx_start/tx_busy).
- Decodes a byte-serial command protocol: write one byte of CPU data memory, or read one byte and return it.
- Sits between the UART and the 8-bit CPU's data-memory port as the debug/load path for the 8-bit CPU.

---
 rtl/uart_mem_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_mem_bridge.sv
// Byte-serial debug/load engine between a UART user interface and the CPU data-memory port.
// Frames: 'W' addr data -> write + 'K'; 'R' addr -> read + data byte; anything else -> '?'.
module uart_mem_bridge #(
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       cmd_err,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // Expiry is detected one count early so the abort lands on the TIMEOUT_CYCLES-th idle cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, SEND, WAIT_TX
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic             busy_q, busy_d;
  logic             cmd_err_q, cmd_err_d;
  logic             timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    cmd_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            cmd_d   = rx_data;
            cnt_d   = '0;
            state_d = GET_ADDR;
          end else begin
            cmd_err_d = 1'b1;
            tx_data_d = NAK_BYTE;
            state_d   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_ready) begin
          mem_addr_d = rx_data;
          cnt_d      = '0;
          state_d    = (cmd_q == CMD_WRITE) ? GET_DATA : MEM_RD;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_ready) begin
          mem_wdata_d = rx_data;
          cnt_d       = '0;
          state_d     = MEM_WR;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_WR: begin
        tx_data_d = ACK_BYTE;
        state_d   = SEND;
      end
      MEM_RD:  state_d = RD_WAIT;
      RD_WAIT: begin
        tx_data_d = mem_rdata;
        state_d   = SEND;
      end
      SEND:    if (!tx_busy) state_d = WAIT_TX;
      WAIT_TX: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and busy are registered from the next state so they line up with the state itself.
    mem_we_d = (state_d == MEM_WR);
    mem_re_d = (state_d == MEM_RD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      busy_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      cnt_q         <= cnt_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      busy_q        <= busy_d;
      cmd_err_q     <= cmd_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Start is qualified by the live tx_busy so the request goes out in the first free SEND cycle.
  assign tx_start    = (state_q == SEND) && !tx_busy;
  assign tx_data     = tx_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;
  assign timeout_err = timeout_err_q;

endmodule
